// File: rtl/data_sram_like_slave_if.sv
// SRAM-like data port between the pipeline's load/store path (master) and the data memory (slave).
interface data_sram_like_slave_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/data_sram_like_slave.sv
// Word-organised data memory answering SRAM-like requests in order after a fixed latency,
// with a bounded in-order queue of outstanding responses.
module data_sram_like_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    data_sram_like_slave_if.slave  bus
);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int PTR_W  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam bit BYPASS = (LATENCY == 1);

    logic [31:0]      mem_r     [0:DEPTH-1];
    logic             q_load_r  [0:OUTSTANDING-1];
    logic [31:0]      q_data_r  [0:OUTSTANDING-1];
    logic [2:0]       q_age_r   [0:OUTSTANDING-1];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [3:0]       cnt_r;
    logic             resetn_q_r;
    logic             data_ok_r;
    logic [31:0]      rdata_r;

    logic [ADDR_WIDTH-1:0] idx_s;
    logic [31:0]           rd_word_s;
    logic                  addr_ok_s;
    logic                  accept_s;
    logic                  enq_s;
    logic                  retire_s;
    logic                  unused_addr_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  wen);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = wen[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUTSTANDING - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Acceptance and retire decode; the full check deliberately ignores a same-cycle retire.
    always_comb begin
        idx_s         = bus.data_sram_addr[ADDR_WIDTH+1:2];
        rd_word_s     = mem_r[idx_s];
        addr_ok_s     = resetn_q_r && (cnt_r < 4'(OUTSTANDING));
        accept_s      = bus.data_sram_req && addr_ok_s;
        unused_addr_s = ^{bus.data_sram_addr[31:ADDR_WIDTH+2], bus.data_sram_addr[1:0]};
        if (BYPASS) begin
            enq_s    = 1'b0;
            retire_s = 1'b0;
        end else begin
            enq_s    = accept_s;
            retire_s = (cnt_r != 4'd0) && (q_age_r[head_r] == 3'(LATENCY - 1));
        end
    end

    // Memory array: byte-lane stores at acceptance; never cleared by reset.
    always_ff @(posedge clk) begin
        if (resetn && accept_s && bus.data_sram_wr) begin
            mem_r[idx_s] <= merge_bytes(rd_word_s, bus.data_sram_wdata, bus.data_sram_wen);
        end
    end

    // Queue payload: loads capture the word at acceptance, so later stores cannot alter them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < OUTSTANDING; i++) begin
            q_age_r[i] <= q_age_r[i] + 3'd1;
        end
        if (resetn && enq_s) begin
            q_load_r[tail_r] <= !bus.data_sram_wr;
            q_data_r[tail_r] <= bus.data_sram_wr ? 32'd0 : rd_word_s;
            q_age_r[tail_r]  <= 3'd1;
        end
    end

    // Pointers, occupancy and registered response outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resetn_q_r <= 1'b0;
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            cnt_r      <= 4'd0;
            data_ok_r  <= 1'b0;
            rdata_r    <= 32'd0;
        end else begin
            resetn_q_r <= 1'b1;
            if (enq_s) begin
                tail_r <= ptr_inc(tail_r);
            end
            if (retire_s) begin
                head_r <= ptr_inc(head_r);
            end
            case ({enq_s, retire_s})
                2'b10:   cnt_r <= cnt_r + 4'd1;
                2'b01:   cnt_r <= cnt_r - 4'd1;
                default: cnt_r <= cnt_r;
            endcase
            if (BYPASS) begin
                data_ok_r <= accept_s;
                rdata_r   <= (accept_s && !bus.data_sram_wr) ? rd_word_s : 32'd0;
            end else begin
                data_ok_r <= retire_s;
                rdata_r   <= (retire_s && q_load_r[head_r]) ? q_data_r[head_r] : 32'd0;
            end
        end
    end

    assign bus.data_sram_addr_ok = addr_ok_s;
    assign bus.data_sram_data_ok = data_ok_r;
    assign bus.data_sram_rdata   = rdata_r;
endmodule
